// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, LSB-first data, optional parity, stop bit.
// One clock per bit; TX_OUT and Busy are registered and aligned with each other.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_par_en;
  logic             r_par_typ;
  logic             r_tx;
  logic             r_busy;

  logic [CW-1:0]    w_cnt_nxt;
  logic             w_parity;

  assign w_cnt_nxt = r_cnt + 1'b1;
  // Parity always comes from the latched word, never from live P_DATA.
  assign w_parity  = (^r_data) ^ r_par_typ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (DATA_VALID) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= START;
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        START: begin
          r_tx    <= r_data[0];
          r_cnt   <= '0;
          r_state <= DATA;
        end
        DATA: begin
          // The counter names the bit currently on the line; it stops at the last bit.
          if (r_cnt == LAST_BIT) begin
            if (r_par_en) begin
              r_tx    <= w_parity;
              r_state <= PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
            r_tx  <= r_data[w_cnt_nxt];
          end
        end
        PARITY: begin
          r_tx    <= 1'b1;
          r_state <= STOP;
        end
        STOP: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule
